// File: rtl/cpu6_pipereg_stage_pkg.sv
// Shared widths, stage state encoding and per-stage ctrl sizes for cpu6 pipeline registers.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cpu6_pipereg_stage_pkg;

    localparam int CPU6_XLEN          = 32;
    localparam int CPU6_PIPE_OCC_SIZE = 2;

    // ID/EX control bundle: memwrite, memtoreg, branchtype, alusrc,
    // regwrite, jump, alucontrol, immtype.
    localparam int CPU6_IDEX_CTRL_SIZE = 1 + 1 + 3 + 1 + 1 + 1 + 4 + 3;

    // The encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [CPU6_PIPE_OCC_SIZE-1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/cpu6_pipereg_stage_if.sv
// Valid/ready handshake bundle carrying one pipeline entry (ctrl + data).
// Latency: n/a (wires only).
// Backpressure: master holds valid/ctrl/data until slave asserts ready.
// Signals: valid, ready, ctrl[CTRL_W], data[DATA_W].
interface cpu6_pipereg_stage_if
    import cpu6_pipereg_stage_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = CPU6_XLEN
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/cpu6_dffre.sv
// Register slot with enable and optional synchronous active-low reset to zero.
// Latency: 1 cycle from d/en to q.
// Backpressure: none; en alone decides when the slot loads.
// Ports: clk, reset (active-low, sync), en, d[W], q[W].
module cpu6_dffre #(
    parameter int W      = 1,
    parameter bit RST_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (RST_EN && !reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cpu6_pipereg_stage.sv
// Inter-stage pipeline register with stall/flush and an optional 2-entry skid buffer.
// Latency: 1 cycle from accept to out valid.
// Backpressure: SKID=1 -> registered up.ready (low only when both slots full);
//               SKID=0 -> up.ready = ~out_valid | deq.
// Ports: clk, reset (sync, active-low), flush, stall, up (slave), dn (master), occupancy.
module cpu6_pipereg_stage
    import cpu6_pipereg_stage_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = CPU6_XLEN,
    parameter bit SKID   = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          stall,
    cpu6_pipereg_stage_if.slave           up,
    cpu6_pipereg_stage_if.master          dn,
    output logic [CPU6_PIPE_OCC_SIZE-1:0] occupancy
);

    occ_state_e        state_q;
    occ_state_e        state_d;
    logic              rdy_q;
    logic              out_valid;
    logic              accept;
    logic              deq;
    logic              head_en;
    logic              head_from_skid;
    logic              skid_en;
    logic [CTRL_W-1:0] head_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [CTRL_W-1:0] head_ctrl_d;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] skid_data;
    logic [DATA_W-1:0] head_data_d;

    assign out_valid = (state_q != OCC_EMPTY);
    // A flush kills the head, so a coincident downstream handshake is not a dequeue.
    assign deq       = out_valid & dn.ready & ~stall & ~flush;
    assign up.ready  = SKID ? rdy_q : (~out_valid | deq);
    assign accept    = up.valid & up.ready & ~flush;

    always_comb begin
        state_d        = state_q;
        head_en        = 1'b0;
        head_from_skid = 1'b0;
        skid_en        = 1'b0;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_d = OCC_ONE;
                        head_en = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && deq) begin
                        head_en = 1'b1;
                    end else if (accept && SKID) begin
                        // Head is held, so the newcomer parks behind it.
                        state_d = OCC_TWO;
                        skid_en = 1'b1;
                    end else if (deq) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (deq) begin
                        state_d        = OCC_ONE;
                        head_en        = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= OCC_EMPTY;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != OCC_TWO);
        end
    end

    assign head_ctrl_d = head_from_skid ? skid_ctrl : up.ctrl;
    assign head_data_d = head_from_skid ? skid_data : up.data;

    cpu6_dffre #(.W(CTRL_W), .RST_EN(1'b1)) u_head_ctrl (
        .clk(clk), .reset(reset), .en(head_en), .d(head_ctrl_d), .q(head_ctrl)
    );
    cpu6_dffre #(.W(DATA_W), .RST_EN(1'b0)) u_head_data (
        .clk(clk), .reset(reset), .en(head_en), .d(head_data_d), .q(head_data)
    );
    cpu6_dffre #(.W(CTRL_W), .RST_EN(1'b1)) u_skid_ctrl (
        .clk(clk), .reset(reset), .en(skid_en), .d(up.ctrl), .q(skid_ctrl)
    );
    cpu6_dffre #(.W(DATA_W), .RST_EN(1'b0)) u_skid_data (
        .clk(clk), .reset(reset), .en(skid_en), .d(up.data), .q(skid_data)
    );

    // Bubbles must never carry side-effecting control bits downstream.
    assign dn.valid  = out_valid;
    assign dn.ctrl   = out_valid ? head_ctrl : '0;
    assign dn.data   = head_data;
    assign occupancy = state_q;

endmodule

// File: tb/tb_cpu6_pipereg_stage.sv
// Bench for cpu6_pipereg_stage: one SKID=1 and one SKID=0 instance with scoreboards.
// Latency: n/a.
// Backpressure: driven directly by the stimulus sequence.
module tb_cpu6_pipereg_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_flush, s_stall, n_flush, n_stall;
    logic [1:0] s_occ, n_occ;

    int n_chk  = 0;
    int n_fail = 0;
    int s_deq  = 0;
    int n_deq  = 0;
    bit mon_en = 1'b0;

    logic [39:0] s_sb[$];
    logic [39:0] n_sb[$];
    logic [39:0] s_exp, n_exp;

    always #5 clk = ~clk;

    cpu6_pipereg_stage_if #(.CTRL_W(8), .DATA_W(32)) s_up ();
    cpu6_pipereg_stage_if #(.CTRL_W(8), .DATA_W(32)) s_dn ();
    cpu6_pipereg_stage_if #(.CTRL_W(8), .DATA_W(32)) n_up ();
    cpu6_pipereg_stage_if #(.CTRL_W(8), .DATA_W(32)) n_dn ();

    cpu6_pipereg_stage #(.CTRL_W(8), .DATA_W(32), .SKID(1'b1)) u_skid (
        .clk(clk), .reset(reset), .flush(s_flush), .stall(s_stall),
        .up(s_up), .dn(s_dn), .occupancy(s_occ)
    );
    cpu6_pipereg_stage #(.CTRL_W(8), .DATA_W(32), .SKID(1'b0)) u_noskid (
        .clk(clk), .reset(reset), .flush(n_flush), .stall(n_stall),
        .up(n_up), .dn(n_dn), .occupancy(n_occ)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one entry on the SKID=1 upstream side and hold it until accepted.
    task automatic push(input logic [7:0] c, input logic [31:0] d);
        bit acc = 1'b0;
        s_up.valid = 1'b1;
        s_up.ctrl  = c;
        s_up.data  = d;
        for (int k = 0; k < 20; k++) begin
            #5;
            if (s_up.ready) begin
                acc = 1'b1;
                break;
            end
            tick();
        end
        if (!acc) chk("push_timeout", 64'(acc), 64'd1);
        tick();
    endtask

    // Scoreboards sample 8 units after the edge, when all inputs and outputs are settled.
    always begin
        @(posedge clk);
        #8;
        if (mon_en) begin
            if (s_dn.valid && s_dn.ready && !s_stall && !s_flush) begin
                s_deq++;
                if (s_sb.size() == 0) chk("skid_unexpected_out", 64'd1, 64'd0);
                else begin
                    s_exp = s_sb.pop_front();
                    chk("skid_out", 64'({s_dn.ctrl, s_dn.data}), 64'(s_exp));
                end
            end
            if (s_up.valid && s_up.ready && !s_flush) s_sb.push_back({s_up.ctrl, s_up.data});
            if (s_flush) s_sb.delete();
            if (!s_dn.valid) chk("skid_bubble_ctrl", 64'(s_dn.ctrl), 64'd0);
        end
    end

    always begin
        @(posedge clk);
        #8;
        if (mon_en) begin
            if (n_dn.valid && n_dn.ready && !n_stall && !n_flush) begin
                n_deq++;
                if (n_sb.size() == 0) chk("noskid_unexpected_out", 64'd1, 64'd0);
                else begin
                    n_exp = n_sb.pop_front();
                    chk("noskid_out", 64'({n_dn.ctrl, n_dn.data}), 64'(n_exp));
                end
            end
            if (n_up.valid && n_up.ready && !n_flush) n_sb.push_back({n_up.ctrl, n_up.data});
            if (n_flush) n_sb.delete();
            if (!n_dn.valid) chk("noskid_bubble_ctrl", 64'(n_dn.ctrl), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset = 1'b0;
        s_flush = 1'b0; s_stall = 1'b0; n_flush = 1'b0; n_stall = 1'b0;
        s_up.valid = 1'b1; s_up.ctrl = 8'hEE; s_up.data = 32'hDEADBEEF; s_dn.ready = 1'b0;
        n_up.valid = 1'b1; n_up.ctrl = 8'hEE; n_up.data = 32'hDEADBEEF; n_dn.ready = 1'b0;

        // 1: reset held 3 cycles with in_valid=1
        repeat (3) tick();
        #5;
        chk("rst_occ", 64'(s_occ), 64'd0);
        chk("rst_out_valid", 64'(s_dn.valid), 64'd0);
        chk("rst_out_ctrl", 64'(s_dn.ctrl), 64'd0);
        chk("rst_noskid_occ", 64'(n_occ), 64'd0);
        chk("rst_noskid_valid", 64'(n_dn.valid), 64'd0);
        tick();
        reset = 1'b1;
        s_up.valid = 1'b0;
        n_up.valid = 1'b0;
        mon_en = 1'b1;
        #5;
        chk("rel_in_ready", 64'(s_up.ready), 64'd1);
        chk("rel_noskid_in_ready", 64'(n_up.ready), 64'd1);
        chk("rel_occ", 64'(s_occ), 64'd0);

        // 2: streaming with out_ready=1
        tick();
        s_dn.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_up.valid = 1'b1;
            s_up.ctrl  = 8'hA5;
            s_up.data  = {i[23:0], 8'h13};
            #5;
            chk("stream_in_ready", 64'(s_up.ready), 64'd1);
            chk("stream_out_valid", 64'(s_dn.valid), 64'(i > 0));
            tick();
        end
        s_up.valid = 1'b0;
        #5;
        chk("stream_tail_valid", 64'(s_dn.valid), 64'd1);
        tick();
        #5;
        chk("stream_drained", 64'(s_dn.valid), 64'd0);

        // 3: fill both slots, third entry waits upstream, then FIFO drain
        tick();
        s_dn.ready = 1'b0;
        push(8'h11, 32'h0000_1111);
        push(8'h22, 32'h0000_2222);
        s_up.valid = 1'b1;
        s_up.ctrl  = 8'h33;
        s_up.data  = 32'h0000_3333;
        #5;
        chk("full_occ", 64'(s_occ), 64'd2);
        chk("full_in_ready", 64'(s_up.ready), 64'd0);
        chk("full_head_ctrl", 64'(s_dn.ctrl), 64'h11);
        tick();
        #5;
        chk("full_occ_hold", 64'(s_occ), 64'd2);
        chk("full_in_ready_hold", 64'(s_up.ready), 64'd0);
        tick();
        s_dn.ready = 1'b1;
        push(8'h33, 32'h0000_3333);
        s_up.valid = 1'b0;
        tick();
        tick();
        #5;
        chk("drain_occ", 64'(s_occ), 64'd0);

        // 4: flush while full and out_ready=1
        tick();
        s_dn.ready = 1'b0;
        push(8'h44, 32'h0000_4444);
        push(8'h55, 32'h0000_5555);
        s_up.valid = 1'b0;
        #5;
        chk("pre_flush_occ", 64'(s_occ), 64'd2);
        tick();
        s_flush = 1'b1;
        s_dn.ready = 1'b1;
        d0 = s_deq;
        tick();
        s_flush = 1'b0;
        s_dn.ready = 1'b0;
        #5;
        chk("flush_occ", 64'(s_occ), 64'd0);
        chk("flush_out_valid", 64'(s_dn.valid), 64'd0);
        chk("flush_out_ctrl", 64'(s_dn.ctrl), 64'd0);
        chk("flush_no_deq", 64'(s_deq), 64'(d0));
        chk("flush_in_ready", 64'(s_up.ready), 64'd1);

        // 5: stall holds head for 4 cycles
        tick();
        s_stall = 1'b1;
        s_dn.ready = 1'b1;
        push(8'h5A, 32'h0000_5A5A);
        s_up.valid = 1'b0;
        d0 = s_deq;
        for (int k = 0; k < 4; k++) begin
            #5;
            chk("stall_ctrl", 64'(s_dn.ctrl), 64'h5A);
            chk("stall_valid", 64'(s_dn.valid), 64'd1);
            chk("stall_no_deq", 64'(s_deq), 64'(d0));
            tick();
        end
        s_stall = 1'b0;
        tick();
        #5;
        chk("unstall_one_deq", 64'(s_deq), 64'(d0 + 1));
        chk("unstall_empty", 64'(s_dn.valid), 64'd0);

        // 6: SKID=0, accept and deq every cycle
        tick();
        n_dn.ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_up.valid = 1'b1;
            n_up.ctrl  = 8'(i + 1);
            n_up.data  = 32'hC0DE_0000 + 32'(i);
            #5;
            chk("noskid_in_ready", 64'(n_up.ready), 64'd1);
            if (i > 0) chk("noskid_occ", 64'(n_occ), 64'd1);
            tick();
        end
        n_up.valid = 1'b0;
        #5;
        chk("noskid_tail_occ", 64'(n_occ), 64'd1);
        tick();
        #5;
        chk("noskid_drained_occ", 64'(n_occ), 64'd0);
        chk("noskid_deq_count", 64'(n_deq), 64'd16);

        chk("skid_deq_total", 64'(s_deq), 64'd12);
        chk("skid_sb_empty", 64'(s_sb.size()), 64'd0);
        chk("noskid_sb_empty", 64'(n_sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
